// File: rtl/led_frame_ctrl_if.sv
// Write-side bus of the LED frame controller.
//
// Carries the back-buffer row write handshake and the commit request/status.
//   i_wr_valid        writer -> ctrl  write request
//   o_wr_ready        ctrl -> writer  back buffer accepts a write this cycle
//   i_wr_row          writer -> ctrl  target row of the write
//   i_wr_data         writer -> ctrl  row column data, 1 = LED on
//   i_commit          writer -> ctrl  request back-to-front swap at next frame boundary
//   o_commit_pending  ctrl -> writer  commit requested, swap not yet taken
//
// master: the writer.  slave: the frame controller.
interface led_frame_ctrl_if #(
    parameter int NUM_ROWS_WIDTH = 2,
    parameter int NUM_COLS       = 8
);
    logic                      i_wr_valid;
    logic                      o_wr_ready;
    logic [NUM_ROWS_WIDTH-1:0] i_wr_row;
    logic [NUM_COLS-1:0]       i_wr_data;
    logic                      i_commit;
    logic                      o_commit_pending;

    modport master (
        output i_wr_valid, i_wr_row, i_wr_data, i_commit,
        input  o_wr_ready, o_commit_pending
    );

    modport slave (
        input  i_wr_valid, i_wr_row, i_wr_data, i_commit,
        output o_wr_ready, o_commit_pending
    );
endinterface

// File: rtl/led_frame_ctrl.sv
// Double-buffered frame controller and scan sequencer for a row-multiplexed
// LED matrix.
//
// Writers fill the back buffer one row at a time and request a commit; the
// buffers swap (pointer toggle, no copy) only at the frame boundary, so a
// frame is never torn. The front buffer is scanned row by row, each row
// preceded by an all-off blanking gap to suppress ghosting.
//
// Ports:
//   clk            system clock
//   i_rst_n        asynchronous active-low reset
//   wr             write/commit bus (led_frame_ctrl_if.slave)
//   i_brightness   4-bit PWM duty, only with LED_BRIGHTNESS_PWM_EN defined
//   o_frame_start  one-cycle pulse on the first blank cycle of row 0
//   o_cols         registered column drive
//   o_rows         registered one-hot row select, zero while blanked
//
// Optional feature macro: LED_BRIGHTNESS_PWM_EN. When defined, columns are
// only driven while (drive tick mod 16) < brightness sampled at DRIVE entry;
// this needs TICK_WIDTH >= 4. When undefined, columns are driven for the
// whole DRIVE window.
module led_frame_ctrl #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_ROWS_WIDTH = 2,
    parameter int NUM_COLS       = 8,
    parameter int ROW_TICKS      = 1000,
    parameter int BLANK_TICKS    = 8,
    parameter int TICK_WIDTH     = 10
) (
    input  logic                clk,
    input  logic                i_rst_n,
    led_frame_ctrl_if.slave     wr,
`ifdef LED_BRIGHTNESS_PWM_EN
    input  logic [3:0]          i_brightness,
`endif
    output logic                o_frame_start,
    output logic [NUM_COLS-1:0] o_cols,
    output logic [NUM_ROWS-1:0] o_rows
);
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] frame_t;

    localparam logic [TICK_WIDTH-1:0]     BLANK_LAST = TICK_WIDTH'(BLANK_TICKS - 1);
    localparam logic [TICK_WIDTH-1:0]     ROW_LAST   = TICK_WIDTH'(ROW_TICKS - 1);
    localparam logic [NUM_ROWS_WIDTH-1:0] ROW_MAX    = NUM_ROWS_WIDTH'(NUM_ROWS - 1);

    scan_state_e               state_q, state_d;
    logic [TICK_WIDTH-1:0]     tick_q, tick_d;
    logic [NUM_ROWS_WIDTH-1:0] row_q, row_d;
    frame_t [1:0]              fb_q, fb_d;          // the two frame buffers
    logic                      front_sel_q, front_sel_d;
    logic                      pending_q, pending_d;
    logic                      frame_start_q, frame_start_d;
    logic [NUM_COLS-1:0]       cols_q, cols_d;
    logic [NUM_ROWS-1:0]       rows_q, rows_d;

    logic                      wr_fire;
    logic                      row_ok;
    logic [31:0]               wr_row_ext;
    logic                      at_boundary;
    logic                      col_en;

`ifdef LED_BRIGHTNESS_PWM_EN
    logic [3:0]                bright_q, bright_d;
`endif

    // Back buffer is frozen while a commit waits for the boundary.
    assign wr.o_wr_ready       = ~pending_q;
    assign wr.o_commit_pending = pending_q;

    assign wr_fire    = wr.i_wr_valid & ~pending_q;
    // Out-of-range rows complete the handshake but are dropped.
    assign wr_row_ext = 32'(wr.i_wr_row);
    assign row_ok     = (wr_row_ext < 32'(NUM_ROWS));

    assign at_boundary = (state_q == DRIVE) && (tick_q == ROW_LAST) && (row_q == ROW_MAX);

`ifdef LED_BRIGHTNESS_PWM_EN
    assign col_en = (tick_q[3:0] < bright_q);
`else
    assign col_en = 1'b1;
`endif

    // Scan FSM plus buffer/commit next-state.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q + TICK_WIDTH'(1);
        row_d       = row_q;
        fb_d        = fb_q;
        front_sel_d = front_sel_q;
        pending_d   = pending_q;
`ifdef LED_BRIGHTNESS_PWM_EN
        bright_d    = bright_q;
`endif

        case (state_q)
            BLANK: begin
                if (tick_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    tick_d  = '0;
`ifdef LED_BRIGHTNESS_PWM_EN
                    bright_d = i_brightness;
`endif
                end
            end
            DRIVE: begin
                if (tick_q == ROW_LAST) begin
                    state_d = BLANK;
                    tick_d  = '0;
                    row_d   = (row_q == ROW_MAX) ? '0 : row_q + NUM_ROWS_WIDTH'(1);
                end
            end
            default: begin
                state_d = BLANK;
                tick_d  = '0;
            end
        endcase

        if (wr_fire && row_ok) begin
            fb_d[~front_sel_q][wr.i_wr_row] = wr.i_wr_data;
        end

        // A commit arriving in the boundary cycle itself only sets pending;
        // the swap waits for the next boundary.
        if (at_boundary && pending_q) begin
            front_sel_d = ~front_sel_q;
            pending_d   = 1'b0;
        end else if (wr.i_commit && !pending_q) begin
            pending_d = 1'b1;
        end
    end

    // Outputs are a registered view of the current state: one cycle behind
    // the state change, frame_start aligned with the first blanked output.
    always_comb begin
        frame_start_d = (state_q == BLANK) && (row_q == '0) && (tick_q == '0);
        rows_d        = '0;
        cols_d        = '0;
        if (state_q == DRIVE) begin
            rows_d = NUM_ROWS'(1) << row_q;
            if (col_en) begin
                cols_d = fb_q[front_sel_q][row_q];
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= BLANK;
            tick_q        <= '0;
            row_q         <= '0;
            fb_q          <= '0;
            front_sel_q   <= 1'b0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            cols_q        <= '0;
            rows_q        <= '0;
`ifdef LED_BRIGHTNESS_PWM_EN
            bright_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            row_q         <= row_d;
            fb_q          <= fb_d;
            front_sel_q   <= front_sel_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            cols_q        <= cols_d;
            rows_q        <= rows_d;
`ifdef LED_BRIGHTNESS_PWM_EN
            bright_q      <= bright_d;
`endif
        end
    end

    assign o_frame_start = frame_start_q;
    assign o_cols        = cols_q;
    assign o_rows        = rows_q;
endmodule

// File: tb/tb_led_frame_ctrl.sv
// Self-checking bench for led_frame_ctrl (4 rows, 8 cols, ROW_TICKS=4,
// BLANK_TICKS=2, 24-cycle frame). Expected display cycles are pushed to a
// scoreboard as stimulus is applied and popped every cycle at the falling
// clock edge; handshake/commit status is checked inline.
module tb_led_frame_ctrl;
    localparam int NR    = 4;
    localparam int NRW   = 2;
    localparam int NC    = 8;
    localparam int RT    = 4;
    localparam int BT    = 2;
    localparam int TW    = 10;
    localparam int SLOT  = BT + RT;
    localparam int FRAME = NR * SLOT;

    typedef struct packed {
        logic          fs;
        logic [NR-1:0] rows;
        logic [NC-1:0] cols;
    } exp_t;

    logic          clk;
    logic          i_rst_n;
    logic          o_frame_start;
    logic [NC-1:0] o_cols;
    logic [NR-1:0] o_rows;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    led_frame_ctrl_if #(.NUM_ROWS_WIDTH(NRW), .NUM_COLS(NC)) wr_if ();

    led_frame_ctrl #(
        .NUM_ROWS(NR), .NUM_ROWS_WIDTH(NRW), .NUM_COLS(NC),
        .ROW_TICKS(RT), .BLANK_TICKS(BT), .TICK_WIDTH(TW)
    ) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .wr            (wr_if),
`ifdef LED_BRIGHTNESS_PWM_EN
        // full duty over a 4-tick row, so the display matches the plain build
        .i_brightness  (4'd15),
`endif
        .o_frame_start (o_frame_start),
        .o_cols        (o_cols),
        .o_rows        (o_rows)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame as seen on the pins, starting at the frame_start cycle.
    task automatic push_frame(input logic [NC-1:0] d0, input logic [NC-1:0] d1,
                              input logic [NC-1:0] d2, input logic [NC-1:0] d3);
        logic [NR-1:0][NC-1:0] d;
        exp_t e;
        d = {d3, d2, d1, d0};
        for (int c = 0; c < FRAME; c++) begin
            e.fs = (c == 0);
            if ((c % SLOT) < BT) begin
                e.rows = '0;
                e.cols = '0;
            end else begin
                e.rows = NR'(1) << (c / SLOT);
                e.cols = d[c / SLOT];
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic run_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_empty: observed=none expected=entry at cycle %0d", i);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("frame_start[%0d]", i), o_frame_start, e.fs);
                chk($sformatf("rows[%0d]", i), o_rows, e.rows);
                chk($sformatf("cols[%0d]", i), o_cols, e.cols);
            end
            @(negedge clk);
        end
    endtask

    task automatic drive_wr(input logic v, input logic [NRW-1:0] r, input logic [NC-1:0] d);
        wr_if.i_wr_valid = v;
        wr_if.i_wr_row   = r;
        wr_if.i_wr_data  = d;
    endtask

    // Frames F..F+3, entered at cycle 0 of F; n is the cycle index from F.
    task automatic stim_swap();
        @(negedge clk);                                   // n=1
        chk("ready_idle", wr_if.o_wr_ready, 1'b1);
        drive_wr(1'b1, 2'd0, 8'hA5);
        @(negedge clk);                                   // n=2
        drive_wr(1'b1, 2'd1, 8'h3C);
        @(negedge clk);                                   // n=3
        drive_wr(1'b1, 2'd2, 8'h0F);
        @(negedge clk);                                   // n=4: write + commit together
        drive_wr(1'b1, 2'd3, 8'hFF);
        wr_if.i_commit = 1'b1;
        @(negedge clk);                                   // n=5
        drive_wr(1'b0, 2'd0, 8'h00);
        wr_if.i_commit = 1'b0;
        chk("pending_set", wr_if.o_commit_pending, 1'b1);
        chk("ready_frozen", wr_if.o_wr_ready, 1'b0);
        push_frame(8'hA5, 8'h3C, 8'h0F, 8'hFF);           // F+1
        repeat (17) @(negedge clk);                       // n=22
        chk("pending_hold", wr_if.o_commit_pending, 1'b1);
        @(negedge clk);                                   // n=23: swapped at boundary
        chk("pending_clr", wr_if.o_commit_pending, 1'b0);
        chk("ready_back", wr_if.o_wr_ready, 1'b1);
        repeat (3) @(negedge clk);                        // n=26
        drive_wr(1'b1, 2'd2, 8'h5A);
        @(negedge clk);                                   // n=27
        drive_wr(1'b0, 2'd0, 8'h00);
        repeat (19) @(negedge clk);                       // n=46: boundary cycle of F+1
        chk("pending_pre_bnd", wr_if.o_commit_pending, 1'b0);
        wr_if.i_commit = 1'b1;
        push_frame(8'hA5, 8'h3C, 8'h0F, 8'hFF);           // F+2: no swap yet
        @(negedge clk);                                   // n=47
        wr_if.i_commit = 1'b0;
        chk("pending_bnd_commit", wr_if.o_commit_pending, 1'b1);
        repeat (11) @(negedge clk);                       // n=58
        drive_wr(1'b1, 2'd1, 8'h81);
        @(negedge clk);                                   // n=59
        chk("ready_blocked", wr_if.o_wr_ready, 1'b0);
        repeat (11) @(negedge clk);                       // n=70
        chk("pending_late", wr_if.o_commit_pending, 1'b1);
        chk("ready_late", wr_if.o_wr_ready, 1'b0);
        @(negedge clk);                                   // n=71: swapped
        chk("pending_clr2", wr_if.o_commit_pending, 1'b0);
        chk("ready_after_swap", wr_if.o_wr_ready, 1'b1);
        push_frame(8'h00, 8'h00, 8'h5A, 8'h00);           // F+3
        @(negedge clk);                                   // n=72: held write accepted
        drive_wr(1'b0, 2'd0, 8'h00);
        repeat (5) @(negedge clk);                        // n=77
        wr_if.i_commit = 1'b1;
        @(negedge clk);                                   // n=78
        wr_if.i_commit = 1'b0;
        chk("pending_set3", wr_if.o_commit_pending, 1'b1);
        push_frame(8'hA5, 8'h81, 8'h0F, 8'hFF);           // F+4
    endtask

    initial begin
        i_rst_n = 1'b1;
        drive_wr(1'b0, 2'd0, 8'h00);
        wr_if.i_commit = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_rows", o_rows, 4'b0000);
        chk("rst_cols", o_cols, 8'h00);
        chk("rst_fs", o_frame_start, 1'b0);
        chk("rst_pending", wr_if.o_commit_pending, 1'b0);
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        chk("ready_after_rst", wr_if.o_wr_ready, 1'b1);

        // Idle scan: two blank-content frames, frame_start every 24 cycles.
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        run_cycles(2 * FRAME);

        // Commit mid-frame, commit on the boundary, write held while pending.
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);           // F
        fork
            run_cycles(4 * FRAME);
            stim_swap();
        join

        // F+4: hold commit (pending sets), then reset during row 2 drive.
        wr_if.i_commit = 1'b1;
        run_cycles(15);
        chk("pre_rst_rows", o_rows, 4'b0100);
        chk("pre_rst_cols", o_cols, 8'h0F);
        chk("pre_rst_pending", wr_if.o_commit_pending, 1'b1);
        i_rst_n = 1'b0;
        wr_if.i_commit = 1'b0;
        #1;
        chk("mid_rst_rows", o_rows, 4'b0000);
        chk("mid_rst_cols", o_cols, 8'h00);
        chk("mid_rst_fs", o_frame_start, 1'b0);
        chk("mid_rst_pending", wr_if.o_commit_pending, 1'b0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        chk("ready_after_rst2", wr_if.o_wr_ready, 1'b1);

        // Both buffers cleared: zeros before and after a swap.
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        fork
            run_cycles(2 * FRAME);
            begin
                repeat (3) @(negedge clk);
                wr_if.i_commit = 1'b1;
                @(negedge clk);
                wr_if.i_commit = 1'b0;
                chk("pending_post_rst", wr_if.o_commit_pending, 1'b1);
            end
        join
        chk("fs_third_frame", o_frame_start, 1'b1);
        chk("pending_swapped", wr_if.o_commit_pending, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_frame_ctrl.md
Name: led_frame_ctrl

Overview:
Double-buffered frame controller and scan sequencer for a row-multiplexed LED matrix. Writers load rows into a back buffer through a valid/ready handshake and request a commit. The block swaps the back buffer to the front only at a frame boundary, so the display never tears. It scans the front buffer row by row with a blanking gap between rows to suppress ghosting, and drives the matrix column and row pins directly.

Parameters:
NUM_ROWS, 4, matrix rows scanned per frame
NUM_ROWS_WIDTH, 2, bits to index a row (ceil(log2(NUM_ROWS)))
NUM_COLS, 8, columns per row
ROW_TICKS, 1000, clk cycles each row is driven (>=1)
BLANK_TICKS, 8, clk cycles all outputs are off before each row (>=1)
TICK_WIDTH, 10, counter width; must hold max(ROW_TICKS, BLANK_TICKS)-1

Ports:
clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_wr_valid  in  1  write request
o_wr_ready  out  1  back buffer accepts a write this cycle
i_wr_row  in  NUM_ROWS_WIDTH  target row of write
i_wr_data  in  NUM_COLS  row column data, 1 = LED on
i_commit  in  1  request back-to-front swap at next frame boundary
o_commit_pending  out  1  commit requested, swap not yet taken
o_frame_start  out  1  one-cycle pulse at start of each frame
o_cols  out  NUM_COLS  column drive, registered
o_rows  out  NUM_ROWS  one-hot row select, registered, all-zero when blanked

Behaviour:
- Reset is asynchronous on the falling edge of i_rst_n. All of the following apply immediately, including mid-frame:
  - Both buffers cleared to 0 and front select = buffer 0.
  - Scan row = 0, state = BLANK, tick counter = 0.
  - o_cols = 0, o_rows = 0, o_frame_start = 0, o_commit_pending = 0.
  - o_wr_ready = 1 once reset is released.
- Scan FSM has two states, BLANK and DRIVE:
  - BLANK lasts BLANK_TICKS cycles with o_rows = 0 and o_cols = 0. It then moves to DRIVE with the tick counter cleared.
  - DRIVE lasts ROW_TICKS cycles with o_rows = one-hot(row) and o_cols = front[row]. It then returns to BLANK with row = row+1.
  - Row wraps from NUM_ROWS-1 to 0.
  - Frame period = NUM_ROWS*(BLANK_TICKS+ROW_TICKS) cycles.
- Outputs are registered. o_cols/o_rows reflect the state the FSM entered on the previous edge, giving one cycle of latency from the state change.
- o_frame_start is 1 for exactly the first BLANK cycle of row 0, including the first frame after reset.
- Frame boundary is the last DRIVE cycle of row NUM_ROWS-1:
  - If o_commit_pending = 1 at that edge, front select toggles and pending clears.
  - The new front is displayed from row 0 of the next frame.
- Swap is a pointer toggle with no copy. After a swap, the back buffer holds the previous front contents.
- Handshake:
  - A write is accepted when i_wr_valid & o_wr_ready. It lands in back[i_wr_row] at that edge.
  - o_wr_ready = !o_commit_pending, so the back buffer is frozen until the swap.
  - i_wr_row >= NUM_ROWS: the write is accepted (handshake completes) and the data is dropped.
  - i_wr_valid held with ready low: no write occurs; data and row must stay stable until accepted.
- Commit:
  - i_commit sets pending on the next edge.
  - i_commit while already pending is ignored.
  - Write and commit in the same cycle: the write is included in the committed frame.
  - Commit asserted in the frame-boundary cycle itself: pending sets, and the swap occurs at the following boundary, one frame later.
- Writes never affect the front buffer, so the displayed frame is stable for the whole frame.

Optional Feature:
LED_BRIGHTNESS_PWM_EN:
- Defined:
  - Adds input i_brightness[3:0], sampled on entry to each DRIVE.
  - During DRIVE, o_cols = front[row] only while (drive tick counter mod 16) < sampled brightness, else 0.
  - o_rows stays asserted for the whole DRIVE.
  - Brightness 0 gives a dark display; brightness 15 gives 15/16 duty.
- Undefined: port absent and columns are driven for all of DRIVE.

Test Plan (NUM_ROWS=4, NUM_COLS=8, ROW_TICKS=4, BLANK_TICKS=2, frame = 24 cycles):
1. Release reset, no writes -> o_frame_start pulses every 24 cycles; o_rows sequence per row is 0000 x2 cycles, then 0001 x4, then 0010 x4, and so on; o_cols = 0 throughout.
2. Write rows 0..3 = 8'hA5, 8'h3C, 8'h0F, 8'hFF, then commit mid-frame -> o_commit_pending = 1 and o_wr_ready = 0 until the boundary; the next frame shows those values on rows 0001..1000; pending clears.
3. Commit asserted exactly in the last DRIVE cycle of row 3 -> the current frame boundary does not swap; the swap occurs 24 cycles later.
4. i_wr_valid = 1 while pending -> no acceptance; the write of 8'h81 to row 1 completes on the first cycle after the swap and lands in the new back buffer, with the displayed row 1 unchanged.
5. Assert i_rst_n = 0 during DRIVE of row 2 -> o_cols and o_rows go to 0 immediately; after release, the display shows all zeros and scanning restarts at row 0 with o_frame_start.
6. With LED_BRIGHTNESS_PWM_EN, ROW_TICKS=32, i_brightness = 4 -> each 16-cycle DRIVE window shows columns for 4 cycles and 0 for 12; i_brightness = 0 gives o_cols always 0.
